// File: rtl/alu_pipe.sv
// Pipelined ALU with a single-cycle datapath and an iterative shift-add multiplier.
// Results sit in a registered output stage with a valid/ready handshake.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUK,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             N,
    output logic             Z,
    output logic             P,
    output logic             C
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_PASS = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t               state;
    logic                 accept;
    logic                 load;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     res;
    logic                 res_c;
    logic [WIDTH-1:0]     wb_res;
    logic                 wb_c;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     mplr;
    logic [SHW-1:0]       cnt;

    assign in_ready = (state == IDLE) && !(out_valid && !out_ready) && !Reset;
    assign accept   = in_valid && in_ready;

    assign sum     = {1'b0, A} + {1'b0, B};
    assign acc_nxt = mplr[0] ? acc + mcand : acc;

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (ALUK)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
            end
            OP_AND:  res = A & B;
            OP_NOT:  res = ~A;
            OP_PASS: res = A;
            OP_SUB: begin
                res   = A - B;
                res_c = (A >= B);
            end
            OP_XOR:  res = A ^ B;
            OP_SHL:  res = A << B[SHW-1:0];
            default: ;
        endcase
    end

    // The multiplier finishes into the same output register as the fast path
    always_comb begin
        wb_res = res;
        wb_c   = res_c;
        load   = 1'b0;
        if (state == MUL) begin
            wb_res = acc_nxt[WIDTH-1:0];
            wb_c   = |acc_nxt[2*WIDTH-1:WIDTH];
            load   = (cnt == LAST);
        end else if (state == IDLE) begin
            load   = accept && (ALUK != OP_MUL);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ALU_Out   <= '0;
            N         <= 1'b0;
            Z         <= 1'b0;
            P         <= 1'b0;
            C         <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && ALUK == OP_MUL) begin
                        state     <= MUL;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        mcand     <= {{WIDTH{1'b0}}, A};
                        mplr      <= B;
                        cnt       <= '0;
                    end else if (accept) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + SHW'(1);
                    if (cnt == LAST) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                ALU_Out <= wb_res;
                N       <= wb_res[WIDTH-1];
                Z       <= (wb_res == '0);
                P       <= !wb_res[WIDTH-1] && (wb_res != '0);
                C       <= wb_c;
            end
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe with a result scoreboard.
// Expected values come from a behavioural model of each operation.
module tb_alu_pipe;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
    } exp_t;

    logic         Clk;
    logic         Reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUK;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_Out;
    logic         N;
    logic         Z;
    logic         P;
    logic         C;

    int   checks   = 0;
    int   failures = 0;
    int   popped   = 0;
    exp_t sb[$];

    alu_pipe #(.WIDTH(W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ALUK(ALUK),
        .A(A),
        .B(B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALU_Out(ALU_Out),
        .N(N),
        .Z(Z),
        .P(P),
        .C(C)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        logic [31:0] wide;
        e    = '0;
        wide = 32'(a) + 32'(b);
        case (op)
            3'd0: begin e.r = wide[15:0]; e.c = wide[16]; end
            3'd1: e.r = a & b;
            3'd2: e.r = ~a;
            3'd3: e.r = a;
            3'd4: begin e.r = a - b; e.c = (a >= b); end
            3'd5: e.r = a ^ b;
            3'd6: e.r = a << b[3:0];
            default: begin
                wide = 32'(a) * 32'(b);
                e.r  = wide[15:0];
                e.c  = (wide[31:16] != 16'd0);
            end
        endcase
        return e;
    endfunction

    // Results are compared while the handshake is stable before the edge
    always @(negedge Clk) begin
        if (!Reset && out_valid) begin
            chk("flags_onehot", 32'($onehot({N, Z, P})), 32'd1);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(ALU_Out), 32'hDEAD_0000);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    popped++;
                    chk("res", 32'(ALU_Out), 32'(e.r));
                    chk("c", 32'(C), 32'(e.c));
                    chk("n", 32'(N), 32'(e.r[W-1]));
                    chk("z", 32'(Z), 32'(e.r == '0));
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge Clk);
            #2;
            n++;
        end
        chk(tag, 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        in_valid = 1'b1;
        ALUK     = op;
        A        = a;
        B        = b;
        wait_ready("ready_before_op");
        sb.push_back(model(op, a, b));
        tick();
        in_valid = 1'b0;
        chk("lat1_valid", 32'(out_valid), 32'd1);
        tick();
    endtask

    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        ALUK     = 3'b111;
        A        = a;
        B        = b;
        wait_ready("ready_before_mul");
        sb.push_back(model(3'b111, a, b));
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            chk("mul_busy_valid", 32'(out_valid), 32'd0);
            chk("mul_busy_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("mul_lat_valid", 32'(out_valid), 32'd1);
        chk("hold_ready", 32'(in_ready), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int base;
        Reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ALUK      = 3'b000;
        A         = '0;
        B         = '0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(ALU_Out), 32'd0);
        chk("rst_flags", 32'({N, Z, P, C}), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        Reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        do_op(3'b000, 16'h7FFF, 16'h0001);
        do_op(3'b000, 16'hFFFF, 16'h0001);
        do_op(3'b100, 16'h0003, 16'h0005);
        do_op(3'b100, 16'h0005, 16'h0005);
        do_op(3'b110, 16'h0001, 16'h0013);
        do_op(3'b110, 16'h8421, 16'h000F);
        do_op(3'b010, 16'h0000, 16'h1234);
        do_op(3'b011, 16'h0000, 16'hFFFF);
        do_op(3'b001, 16'hF0F0, 16'h3C3C);
        do_op(3'b101, 16'hF0F0, 16'h3C3C);

        do_mul(16'h0012, 16'h0034);
        do_mul(16'h0100, 16'h0100);
        do_mul(16'hFFFF, 16'hFFFF);

        out_ready = 1'b0;
        do_op(3'b000, 16'h1234, 16'h1111);
        in_valid = 1'b1;
        ALUK     = 3'b101;
        A        = 16'hAAAA;
        B        = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_out", 32'(ALU_Out), 32'h2345);
            chk("stall_c", 32'(C), 32'd0);
            chk("stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        base = popped;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            ALUK     = 3'b000;
            A        = W'(16'h1000 * i);
            B        = W'(i + 1);
            #1;
            chk("b2b_ready", 32'(in_ready), 32'd1);
            sb.push_back(model(3'b000, A, B));
            tick();
            chk("b2b_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        chk("b2b_drained", 32'(popped - base), 32'd8);
        chk("b2b_fall", 32'(out_valid), 32'd0);

        in_valid = 1'b1;
        ALUK     = 3'b111;
        A        = 16'h00FF;
        B        = 16'h00FF;
        wait_ready("ready_before_abort");
        sb.push_back(model(3'b111, A, B));
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        Reset = 1'b1;
        #1;
        chk("abort_rst_ready", 32'(in_ready), 32'd0);
        tick();
        sb.delete();
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_out", 32'(ALU_Out), 32'd0);
        Reset = 1'b0;
        #1;
        chk("abort_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("no_stale", 32'(out_valid), 32'd0);
        end

        do_op(3'b000, 16'h0002, 16'h0003);
        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
